// File: rtl/sensor_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : sensor_input_conditioner
// Description : Input front end for the gas-detection datapath. It takes
//               five raw sensor pins and the operator button into the system
//               clock domain, debounces each one on its own and presents
//               clean levels to the sensor-decode stage. It also produces
//               per-channel change pulses, a button press pulse and a
//               'settled' flag that marks the end of the power-up window.
//
// Ports       : clk          system clock (rising edge)
//               rst          asynchronous active-high reset
//               sen_raw      [4:0] raw sensor pins, asynchronous to clk
//               button_raw   raw operator button pin, 1 = pressed, async
//               sen_out      [4:0] debounced sensor levels (to sen0..sen4)
//               button_out   debounced button level (to button0)
//               sen_change   [4:0] one-cycle pulse when sen_out[i] toggles
//               button_press one-cycle pulse on a debounced button 0->1
//               settled      high once every input has had time to pass
//                            through the whole pipeline since reset
//
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    // Derived from DEBOUNCE_CYCLES; leave at its default.
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] sen_raw,
    input  logic       button_raw,
    output logic [4:0] sen_out,
    output logic       button_out,
    output logic [4:0] sen_change,
    output logic       button_press,
    output logic       settled
);

    localparam int N_CH = 6;   // five sensors plus the button (bit 5)

    // The startup counter has to reach DEBOUNCE_CYCLES+2.
    localparam int ST_W = $clog2(DEBOUNCE_CYCLES + 3);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0]  c_ST_LAST  = ST_W'(DEBOUNCE_CYCLES + 1);

    logic [N_CH-1:0] w_raw;
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] w_out;
    logic [N_CH-1:0] w_change;
    logic [N_CH-1:0] w_fire;
    logic            r_press;
    logic [ST_W-1:0] r_start_cnt;
    logic            r_settled;

    assign w_raw = {button_raw, sen_raw};

    // ------------------------------------------------------------------
    // Two-flop synchronizer for all channels.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce. The counter only runs while the synchronized
    // value differs from the current output; any agreement (a bounce back)
    // clears it, so only an unbroken run of DEBOUNCE_CYCLES differing
    // samples moves the output. The counter is cleared on the update, so
    // it never goes past c_CNT_LAST.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             r_out;
        logic             r_chg;

        assign w_fire[i] = (r_sync2[i] != r_out) && (r_cnt == c_CNT_LAST);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
                r_out <= 1'b0;
                r_chg <= 1'b0;
            end else begin
                r_chg <= w_fire[i];
                if (r_sync2[i] == r_out) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_out <= r_sync2[i];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_out[i]    = r_out;
        assign w_change[i] = r_chg;
    end

    // Press pulse: registered alongside the change pulse, qualified by the
    // value the button output is about to take (a release gives no pulse).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press <= 1'b0;
        end else begin
            r_press <= w_fire[5] & r_sync2[5];
        end
    end

    // ------------------------------------------------------------------
    // Startup counter: counts edges since reset up to DEBOUNCE_CYCLES+2,
    // the worst-case time for an input present at reset release to reach
    // the outputs, then freezes with settled held high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_cnt <= '0;
            r_settled   <= 1'b0;
        end else if (!r_settled) begin
            r_start_cnt <= r_start_cnt + 1'b1;
            if (r_start_cnt == c_ST_LAST) begin
                r_settled <= 1'b1;
            end
        end
    end

    assign sen_out      = w_out[4:0];
    assign button_out   = w_out[5];
    assign sen_change   = w_change[4:0];
    assign button_press = r_press;
    assign settled      = r_settled;

endmodule
`default_nettype wire
